// File: rtl/rf_wb_sink.sv
// rf_wb_sink: architectural 32x32 GPR file plus HI/LO pair, fed by the writeback write buses.
// Latency: writes commit on posedge clk; reads are combinational (zero latency).
// Backpressure: none, the sink always accepts; a bubble is an all-zero bus (we==0).
// Optional feature macro RF_BYPASS_EN: same-cycle write-to-read forwarding for GPR and HI/LO.
module rf_wb_sink #(
  parameter int WB_TO_RF_WD = 38,
  parameter int HILO_WD     = 66,
  parameter int NREG        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
  input  logic [HILO_WD-1:0]     hilo_bus,
  input  logic [4:0]             raddr1,
  output logic [31:0]            rdata1,
  input  logic [4:0]             raddr2,
  output logic [31:0]            rdata2,
  output logic [31:0]            hi_rdata,
  output logic [31:0]            lo_rdata,
  output logic [31:0]            wr_cnt
);

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_req_t;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_req_t;

  wb_req_t   wb_req;
  hilo_req_t hilo_req;

  assign wb_req   = wb_to_rf_bus;
  assign hilo_req = hilo_bus;

  logic [31:0] regs_q [NREG];
  logic [31:0] regs_d [NREG];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // A GPR write commits only with we set and a non-zero address; $0 stays hard-wired to zero.
  logic gpr_wr;
  assign gpr_wr = wb_req.we && (wb_req.waddr != 5'd0);

  // Next-state for GPR array, write counter and HI/LO; the two write paths are independent.
  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (gpr_wr) begin
      regs_d[wb_req.waddr] = wb_req.wdata;
      wr_cnt_d             = wr_cnt_q + 32'd1;
    end
    if (hilo_req.hi_we) hi_d = hilo_req.hi;
    if (hilo_req.lo_we) lo_d = hilo_req.lo;
  end

  // Architectural state; reset clears everything immediately and drops writes presented meanwhile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      regs_q   <= regs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Read ports: $0 reads zero; otherwise registered state, optionally overridden by a same-cycle write.
  always_comb begin
    rdata1   = (raddr1 == 5'd0) ? 32'd0 : regs_q[raddr1];
    rdata2   = (raddr2 == 5'd0) ? 32'd0 : regs_q[raddr2];
    hi_rdata = hi_q;
    lo_rdata = lo_q;
`ifdef RF_BYPASS_EN
    // Forwarding is gated by reset so outputs read zero while reset is held.
    if (rst) begin
      if (gpr_wr && (raddr1 == wb_req.waddr)) rdata1 = wb_req.wdata;
      if (gpr_wr && (raddr2 == wb_req.waddr)) rdata2 = wb_req.wdata;
      if (hilo_req.hi_we) hi_rdata = hilo_req.hi;
      if (hilo_req.lo_we) lo_rdata = hilo_req.lo;
    end
`else
    // Same-cycle hazards are resolved by decode-stage forwarding, so reads show registered state only.
`endif
  end

  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_rf_wb_sink.sv
// tb_rf_wb_sink: directed-vector bench for rf_wb_sink with hand-computed expectations.
// Latency: inputs driven after negedge, combinational reads checked before posedge, commits checked #1 after posedge.
// Backpressure: none; the DUT always accepts.
module tb_rf_wb_sink;

  logic        clk;
  logic        rst;
  logic [37:0] wb_to_rf_bus;
  logic [65:0] hilo_bus;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_rdata, lo_rdata, wr_cnt;

  int n_checks = 0;
  int n_errors = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  rf_wb_sink dut (
    .clk          (clk),
    .rst          (rst),
    .wb_to_rf_bus (wb_to_rf_bus),
    .hilo_bus     (hilo_bus),
    .raddr1       (raddr1),
    .rdata1       (rdata1),
    .raddr2       (raddr2),
    .rdata2       (rdata2),
    .hi_rdata     (hi_rdata),
    .lo_rdata     (lo_rdata),
    .wr_cnt       (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction

  function automatic logic [65:0] hl(input logic hwe, input logic lwe, input logic [31:0] h, input logic [31:0] l);
    return {hwe, lwe, h, l};
  endfunction

  // Present a GPR write across one posedge, then return the bus to a bubble.
  task automatic gpr_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_to_rf_bus = wb(1'b1, a, d);
    @(posedge clk);
    #1;
    wb_to_rf_bus = '0;
  endtask

  initial begin
    rst          = 1'b0;
    wb_to_rf_bus = '0;
    hilo_bus     = '0;
    raddr1       = '0;
    raddr2       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset state: every address on both ports reads zero.
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      check($sformatf("rst_rd1[%0d]", i), rdata1, 32'd0);
      check($sformatf("rst_rd2[%0d]", 31 - i), rdata2, 32'd0);
    end
    check("rst_hi", hi_rdata, 32'd0);
    check("rst_lo", lo_rdata, 32'd0);
    check("rst_cnt", wr_cnt, 32'd0);

    // Basic write then read next cycle.
    gpr_write(5'd5, 32'hDEADBEEF);
    raddr1 = 5'd5;
    #1;
    check("wr5_rd", rdata1, 32'hDEADBEEF);
    check("wr5_cnt", wr_cnt, 32'd1);

    // Write to $0 is ignored.
    gpr_write(5'd0, 32'h12345678);
    raddr1 = 5'd0;
    #1;
    check("wr0_rd", rdata1, 32'd0);
    check("wr0_cnt", wr_cnt, 32'd1);

    // Same-cycle write/read of reg 7 on both ports.
    @(negedge clk);
    wb_to_rf_bus = wb(1'b1, 5'd7, 32'hA5A5A5A5);
    raddr1 = 5'd7;
    raddr2 = 5'd7;
    #1;
    check("same_rd1", rdata1, BYPASS ? 32'hA5A5A5A5 : 32'd0);
    check("same_rd2", rdata2, BYPASS ? 32'hA5A5A5A5 : 32'd0);
    @(posedge clk);
    #1;
    wb_to_rf_bus = '0;
    #1;
    check("after_rd1", rdata1, 32'hA5A5A5A5);
    check("after_rd2", rdata2, 32'hA5A5A5A5);
    check("after_cnt", wr_cnt, 32'd2);

    // HI-only write together with a GPR write to reg 3.
    @(negedge clk);
    hilo_bus     = hl(1'b1, 1'b0, 32'h1, 32'hFFFF);
    wb_to_rf_bus = wb(1'b1, 5'd3, 32'h33);
    #1;
    check("hi_pre", hi_rdata, BYPASS ? 32'h1 : 32'd0);
    check("lo_pre", lo_rdata, 32'd0);
    @(posedge clk);
    #1;
    hilo_bus     = '0;
    wb_to_rf_bus = '0;
    raddr1 = 5'd3;
    raddr2 = 5'd5;
    #1;
    check("hi_post", hi_rdata, 32'h1);
    check("lo_post", lo_rdata, 32'd0);
    check("r3_commit", rdata1, 32'h33);
    check("r5_kept", rdata2, 32'hDEADBEEF);
    check("hilo_cnt", wr_cnt, 32'd3);

    // Both HI and LO written in one cycle; counter untouched.
    @(negedge clk);
    hilo_bus = hl(1'b1, 1'b1, 32'hAAAA, 32'hBBBB);
    @(posedge clk);
    #1;
    hilo_bus = '0;
    #1;
    check("hi_both", hi_rdata, 32'hAAAA);
    check("lo_both", lo_rdata, 32'hBBBB);
    check("both_cnt", wr_cnt, 32'd3);

    // we==0 with live address/data must not change anything.
    @(negedge clk);
    wb_to_rf_bus = wb(1'b0, 5'd3, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    wb_to_rf_bus = '0;
    #1;
    check("we0_r3", rdata1, 32'h33);
    check("we0_cnt", wr_cnt, 32'd3);

    // Fresh reset, preload reg 9 with count 3.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    gpr_write(5'd9, 32'h55);
    gpr_write(5'd1, 32'h11);
    gpr_write(5'd2, 32'h22);
    raddr1 = 5'd9;
    raddr2 = 5'd1;
    #1;
    check("pre_r9", rdata1, 32'h55);
    check("pre_cnt", wr_cnt, 32'd3);

    // Async reset between edges: outputs clear without a clock edge.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_r9", rdata1, 32'd0);
    check("arst_r1", rdata2, 32'd0);
    check("arst_hi", hi_rdata, 32'd0);
    check("arst_lo", lo_rdata, 32'd0);
    check("arst_cnt", wr_cnt, 32'd0);

    // Write presented during reset is discarded, and not forwarded.
    wb_to_rf_bus = wb(1'b1, 5'd9, 32'h77);
    hilo_bus     = hl(1'b1, 1'b1, 32'h5, 32'h6);
    #1;
    check("rstwr_byp", rdata1, 32'd0);
    check("rstwr_hibyp", hi_rdata, 32'd0);
    @(posedge clk);
    #1;
    check("rstwr_r9", rdata1, 32'd0);
    check("rstwr_cnt", wr_cnt, 32'd0);

    // Release reset; first posedge with rst high accepts the write.
    @(negedge clk);
    rst          = 1'b1;
    hilo_bus     = '0;
    wb_to_rf_bus = wb(1'b1, 5'd9, 32'h66);
    @(posedge clk);
    #1;
    wb_to_rf_bus = '0;
    #1;
    check("rel_r9", rdata1, 32'h66);
    check("rel_cnt", wr_cnt, 32'd1);
    check("rel_hi", hi_rdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
